// File: rtl/stream_xbar_arbiter_if.sv
// rtl/stream_xbar_arbiter_if.sv - handshake/grant bundle between stream sources, masters and the arbiter
//
// Purpose: groups the per-source and per-master stream handshake signals plus the
// grant matrix that steers the crossbar datapath.
// Ports (signals):
//   s_valid_i / s_last_i  per-source tvalid / tlast
//   s_dest_i              per-source tdest, source s at [s*T_DEST_WIDTH +: T_DEST_WIDTH]
//   m_ready_i             per-master tready
//   grant_o               grant matrix, bit m*S_DATA_COUNT+s = master m owns source s
//   s_ready_o             per-source tready
//   m_valid_o / m_last_o  per-master tvalid / tlast
// Modports: master = stream side driving the handshake inputs, slave = arbiter.
interface stream_xbar_arbiter_if #(
  parameter int S_DATA_COUNT = 5,
  parameter int M_DATA_COUNT = 3,
  parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
);
  logic [S_DATA_COUNT-1:0]              s_valid_i;
  logic [S_DATA_COUNT-1:0]              s_last_i;
  logic [S_DATA_COUNT*T_DEST_WIDTH-1:0] s_dest_i;
  logic [M_DATA_COUNT-1:0]              m_ready_i;
  logic [S_DATA_COUNT*M_DATA_COUNT-1:0] grant_o;
  logic [S_DATA_COUNT-1:0]              s_ready_o;
  logic [M_DATA_COUNT-1:0]              m_valid_o;
  logic [M_DATA_COUNT-1:0]              m_last_o;

  modport master (
    output s_valid_i, s_last_i, s_dest_i, m_ready_i,
    input  grant_o, s_ready_o, m_valid_o, m_last_o
  );

  modport slave (
    input  s_valid_i, s_last_i, s_dest_i, m_ready_i,
    output grant_o, s_ready_o, m_valid_o, m_last_o
  );
endinterface

// File: rtl/stream_xbar_arbiter.sv
// rtl/stream_xbar_arbiter.sv - per-master round-robin, packet-locked crossbar arbiter
//
// Purpose: every master port independently picks one requesting source in
// round-robin order and holds that grant until the last beat of the packet is
// accepted, so packets never interleave on a master. Also forms the per-source
// ready and per-master valid/last handshake around the data crossbar.
// Ports:
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  stream_xbar_arbiter_if.slave (s_valid_i, s_last_i, s_dest_i, m_ready_i in;
//        grant_o registered, s_ready_o / m_valid_o / m_last_o combinational out)
module stream_xbar_arbiter #(
  parameter int S_DATA_COUNT = 5,
  parameter int M_DATA_COUNT = 3,
  parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input logic                  clk,
  input logic                  rst,
  stream_xbar_arbiter_if.slave bus
);

  localparam int SEL_WIDTH = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state     [M_DATA_COUNT];
  logic [SEL_WIDTH-1:0]    sel       [M_DATA_COUNT];
  logic [SEL_WIDTH-1:0]    ptr       [M_DATA_COUNT];
  logic [S_DATA_COUNT-1:0] grant_row [M_DATA_COUNT];

  logic [T_DEST_WIDTH-1:0] dest      [S_DATA_COUNT];
  logic [S_DATA_COUNT-1:0] locked;
  logic [S_DATA_COUNT-1:0] req       [M_DATA_COUNT];
  logic [M_DATA_COUNT-1:0] found;
  logic [SEL_WIDTH-1:0]    win       [M_DATA_COUNT];
  logic [S_DATA_COUNT-1:0] win_hot   [M_DATA_COUNT];
  logic [M_DATA_COUNT-1:0] done;

  for (genvar g = 0; g < S_DATA_COUNT; g++) begin : g_dest
    assign dest[g] = bus.s_dest_i[g*T_DEST_WIDTH +: T_DEST_WIDTH];
  end

  for (genvar g = 0; g < M_DATA_COUNT; g++) begin : g_grant
    assign bus.grant_o[g*S_DATA_COUNT +: S_DATA_COUNT] = grant_row[g];
  end

  // A source owned by any master must not be offered to another one.
  always_comb begin
    locked = '0;
    for (int m = 0; m < M_DATA_COUNT; m++) begin
      locked = locked | grant_row[m];
    end
  end

  // Dest values >= M_DATA_COUNT never equal a master index, so they never request.
  always_comb begin
    for (int m = 0; m < M_DATA_COUNT; m++) begin
      for (int s = 0; s < S_DATA_COUNT; s++) begin
        req[m][s] = bus.s_valid_i[s] && (dest[s] == T_DEST_WIDTH'(m)) && !locked[s];
      end
    end
  end

  // Round-robin pick: rank is the distance past ptr (1..S), smallest rank wins,
  // so ptr itself gets the lowest priority.
  always_comb begin
    int best;
    int rank;
    for (int m = 0; m < M_DATA_COUNT; m++) begin
      found[m]   = 1'b0;
      win[m]     = '0;
      win_hot[m] = '0;
      best       = S_DATA_COUNT + 1;
      for (int s = 0; s < S_DATA_COUNT; s++) begin
        rank = (s > int'(ptr[m])) ? (s - int'(ptr[m])) : (s + S_DATA_COUNT - int'(ptr[m]));
        if (req[m][s] && (rank < best)) begin
          best       = rank;
          found[m]   = 1'b1;
          win[m]     = SEL_WIDTH'(s);
          win_hot[m] = '0;
          win_hot[m][s] = 1'b1;
        end
      end
    end
  end

  // Handshake steering for busy masters; idle masters expose nothing.
  always_comb begin
    bus.s_ready_o = '0;
    bus.m_valid_o = '0;
    bus.m_last_o  = '0;
    done          = '0;
    for (int m = 0; m < M_DATA_COUNT; m++) begin
      for (int s = 0; s < S_DATA_COUNT; s++) begin
        if ((state[m] == BUSY) && (sel[m] == SEL_WIDTH'(s))) begin
          bus.m_valid_o[m] = bus.s_valid_i[s];
          bus.m_last_o[m]  = bus.s_last_i[s];
          bus.s_ready_o[s] = bus.m_ready_i[m];
          done[m]          = bus.s_valid_i[s] & bus.m_ready_i[m] & bus.s_last_i[s];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int m = 0; m < M_DATA_COUNT; m++) begin
        state[m]     <= IDLE;
        sel[m]       <= '0;
        ptr[m]       <= SEL_WIDTH'(S_DATA_COUNT - 1);
        grant_row[m] <= '0;
      end
    end else begin
      for (int m = 0; m < M_DATA_COUNT; m++) begin
        case (state[m])
          IDLE: begin
            if (found[m]) begin
              state[m]     <= BUSY;
              sel[m]       <= win[m];
              grant_row[m] <= win_hot[m];
            end
          end
          BUSY: begin
            // Grant and sel stay locked until the last beat is accepted.
            if (done[m]) begin
              state[m]     <= IDLE;
              ptr[m]       <= sel[m];
              grant_row[m] <= '0;
            end
          end
          default: begin
            state[m]     <= IDLE;
            grant_row[m] <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/stream_xbar_arbiter.md
Name: stream_xbar_arbiter

Overview:
- Per-master round-robin, packet-locked arbiter that drives the grant matrix of the streaming crossbar datapath.
- Each of M_DATA_COUNT master ports arbitrates independently among the S_DATA_COUNT sources whose destination selects it.
- A grant is held from first beat to the accepted last beat (tlast), so packets never interleave on a master.
- Also produces the per-source ready and per-master valid/last handshake signals around the data crossbar.

Parameters:
- S_DATA_COUNT, 5, number of source (slave-side) ports.
- M_DATA_COUNT, 3, number of master (output) ports.
- T_DEST_WIDTH, $clog2(M_DATA_COUNT), width of each source destination field.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- s_valid_i  input  S_DATA_COUNT  per-source tvalid.
- s_last_i  input  S_DATA_COUNT  per-source tlast.
- s_dest_i  input  S_DATA_COUNT*T_DEST_WIDTH  per-source tdest; source s occupies bits [s*T_DEST_WIDTH +: T_DEST_WIDTH].
- m_ready_i  input  M_DATA_COUNT  per-master tready.
- grant_o  output  S_DATA_COUNT*M_DATA_COUNT  grant matrix; bit m*S_DATA_COUNT+s = master m is connected to source s. Registered.
- s_ready_o  output  S_DATA_COUNT  per-source tready. Combinational.
- m_valid_o  output  M_DATA_COUNT  per-master tvalid. Combinational.
- m_last_o  output  M_DATA_COUNT  per-master tlast. Combinational.

Behaviour:
- Per master m, two states: IDLE and BUSY. Each master also holds:
  - sel[m], the granted source index;
  - ptr[m], the last winner index.
- Reset (rst=1 at a clock edge):
  - all masters go to IDLE;
  - grant_o=0 and ptr[m]=S_DATA_COUNT-1, so source 0 has first priority;
  - s_ready_o, m_valid_o and m_last_o therefore read 0.
  - Reset mid-packet aborts the packet; partial data is not tracked.
- Request definition: source s requests master m iff s_valid_i[s]=1 and s_dest_i field of s equals m.
  - A dest value >= M_DATA_COUNT matches no master. That source is never granted and its s_ready_o stays 0.
- IDLE:
  - If any requester exists, the winner is the first requesting index after ptr[m], searching ptr+1, ptr+2, … with wrap modulo S_DATA_COUNT.
  - At the next edge: sel[m]=winner, grant bit m*S+winner=1, state=BUSY.
  - Arbitration latency is 1 cycle from request to grant; no data moves in the IDLE cycle.
- A source already granted to any master (BUSY) is excluded from arbitration on every other master. A source therefore never holds two grants.
- BUSY, combinational outputs:
  - m_valid_o[m] = s_valid_i[sel];
  - m_last_o[m] = s_last_i[sel];
  - s_ready_o[sel] = m_ready_i[m].
  - Ungranted sources have s_ready_o=0.
- Beat transfer = s_valid_i[sel] & m_ready_i[m].
- BUSY exit:
  - On a transfer with s_last_i[sel]=1: at the next edge the grant bit clears, ptr[m]=sel and state=IDLE.
  - Minimum one idle cycle per master between packets.
- While BUSY:
  - s_dest_i of the granted source is ignored; the grant is locked by sel.
  - s_valid_i dropping mid-packet holds the grant, and m_valid_o follows it to 0.
- Simultaneous events:
  - Masters arbitrate in parallel. Two masters may both grant in the same cycle if their winners differ.
  - Because each source has one dest, two IDLE masters never select the same source.
- Invariants:
  - Each column of grant_o (per master) is at most one-hot.
  - Each source bit is set for at most one master.
- Single-beat packets (valid & last on first granted cycle with ready=1) complete in the first BUSY cycle.

Test Plan:
1. Reset, S=5, M=3:
   - Hold rst 2 cycles with all sources valid.
   - Required: grant_o=0, s_ready_o=0, m_valid_o=0 during reset.
   - After release, first grant appears exactly 1 cycle later.
2. Round-robin fairness:
   - Sources 0, 2 and 4 send continuous 2-beat packets to dest 1, with m_ready_i=3'b111.
   - Required: master 1 grant sequence is 0, 2, 4, 0, 2…, with grant_o bits 5, 7, 9, 5…
   - Each grant lasts exactly 2 cycles, followed by 1 idle cycle.
3. Parallel masters:
   - Source 1 sends to dest 0 while source 3 sends to dest 2 in the same cycle.
   - Required: grant_o bits 1 and 13 rise on the same edge.
   - s_ready_o = 5'b01010 when both masters are ready.
4. Packet lock under backpressure:
   - Source 2 is granted a 4-beat packet on dest 0.
   - Toggle m_ready_i[0] 1,0,0,1,1,1 and drop s_valid_i[2] for 1 cycle.
   - Required: grant bit 2 stays set until the last-beat transfer.
   - Source 0 requesting meanwhile is not granted until 1 cycle after the last beat.
5. Invalid dest:
   - Source 4 has dest=3 with valid=1.
   - Required: no grant bit for source 4 is ever set, and s_ready_o[4]=0 for 20 cycles.
6. Reset mid-packet:
   - Assert rst during beat 2 of a 4-beat packet.
   - Required: grant clears at that edge.
   - After release, arbitration restarts with source 0 having priority.
